// File: rtl/pll_lock_monitor_if.sv
// pll_lock_monitor_if: PLL-side inputs and status outputs of the lock monitor
`timescale 1ns/100ps
interface pll_lock_monitor_if #(parameter int LOSS_W = 3);
    logic              pll_lock;
    logic              clk_mon;
    logic              sys_rst_n;
    logic              locked_ok;
    logic [LOSS_W-1:0] loss_cnt;
    logic              err_flag;
    logic [15:0]       freq_cnt;
    logic              freq_valid;
    modport master (
        output pll_lock, clk_mon,
        input  sys_rst_n, locked_ok, loss_cnt, err_flag, freq_cnt, freq_valid
    );
    modport slave (
        input  pll_lock, clk_mon,
        output sys_rst_n, locked_ok, loss_cnt, err_flag, freq_cnt, freq_valid
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: qualifies PLL lock into a PLL-domain reset and measures the PLL clock frequency
`timescale 1ns/100ps
module pll_lock_monitor #(
    parameter int STABLE_CYCLES = 16,
    parameter int WINDOW        = 256,
    parameter int LOSS_W        = 3
) (
    input logic               clk_tb,
    input logic               rst_n,
    pll_lock_monitor_if.slave mon
);
    typedef enum logic [1:0] {IDLE, STABLE, RUN, LOST} state_t;
    state_t      state;
    logic        l1, lock_s, m1, m2, m3;
    logic        edge_det, wrap;
    logic [15:0] stab_cnt, win_cnt, edge_cnt, edge_inc;
    assign edge_det = m2 & ~m3;
    assign wrap     = win_cnt == 16'(WINDOW - 1);
    assign edge_inc = (edge_det && edge_cnt != 16'hFFFF) ? edge_cnt + 16'd1 : edge_cnt;
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            {l1, lock_s}   <= '0;
            {m1, m2, m3}   <= '0;
            stab_cnt       <= '0;
            win_cnt        <= '0;
            edge_cnt       <= '0;
            mon.loss_cnt   <= '0;
            mon.freq_cnt   <= '0;
            mon.sys_rst_n  <= 1'b0;
            mon.locked_ok  <= 1'b0;
            mon.err_flag   <= 1'b0;
            mon.freq_valid <= 1'b0;
        end else begin
            {l1, lock_s}   <= {mon.pll_lock, l1};
            {m1, m2, m3}   <= {mon.clk_mon, m1, m2};
            win_cnt        <= wrap ? '0 : win_cnt + 16'd1;
            edge_cnt       <= wrap ? '0 : edge_inc;
            mon.freq_cnt   <= wrap ? edge_inc : mon.freq_cnt;
            mon.freq_valid <= wrap;
            case (state)
                IDLE: begin
                    state    <= lock_s ? STABLE : IDLE;
                    stab_cnt <= lock_s ? 16'd1 : 16'd0;
                end
                STABLE: begin
                    if (!lock_s) begin
                        state    <= IDLE;
                        stab_cnt <= '0;
                    end else if (stab_cnt == 16'(STABLE_CYCLES - 1)) begin
                        state         <= RUN;
                        mon.sys_rst_n <= 1'b1;
                        mon.locked_ok <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + 16'd1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state         <= LOST;
                        mon.sys_rst_n <= 1'b0;
                        mon.locked_ok <= 1'b0;
                        mon.loss_cnt  <= (&mon.loss_cnt) ? mon.loss_cnt : mon.loss_cnt + 1'b1;
                        // any earlier loss means this one is at least the second
                        mon.err_flag  <= mon.err_flag | (mon.loss_cnt != '0);
                    end
                end
                LOST: begin
                    state    <= IDLE;
                    stab_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: directed table, reset/glitch sequences and random stimulus against a sample-history model
`timescale 1ns/100ps
module tb_pll_lock_monitor;
    localparam int S    = 16;
    localparam int WIN  = 256;
    localparam int LW   = 3;
    localparam int LMAX = (1 << LW) - 1;

    logic clk_tb, rst_n;
    int   checks, fails, mon_half;
    bit   fixed_mon;

    pll_lock_monitor_if #(.LOSS_W(LW)) mif();
    pll_lock_monitor #(.STABLE_CYCLES(S), .WINDOW(WIN), .LOSS_W(LW)) dut (
        .clk_tb(clk_tb), .rst_n(rst_n), .mon(mif)
    );

    initial begin
        clk_tb = 0;
        forever #1 clk_tb = ~clk_tb;
    end
    // PLL clock toggles on half-ns marks so it never races clk_tb edges
    initial begin
        mif.clk_mon = 0;
        #0.5;
        forever #(mon_half) mif.clk_mon = ~mif.clk_mon;
    end

    // model: lock seen two edges late; run needs S consecutive eligible highs
    int n, p1, p2, streak, total, m_freq;
    bit run, lostp, m_fv;
    bit ms[$];
    bit det[$];

    function automatic void m_reset();
        n = 0; p1 = 0; p2 = 0; streak = 0; total = 0; m_freq = 0;
        run = 0; lostp = 0; m_fv = 0;
        ms = {}; det = {};
        repeat (3) ms.push_back(1'b0);
        det.push_back(1'b0);
    endfunction

    function automatic void m_step(bit lk, bit cm);
        bit ls, loss;
        int s;
        n++;
        ls = p2[0]; p2 = p1; p1 = int'(lk);
        loss = run && !ls;
        streak = (lostp || !ls) ? 0 : streak + 1;
        run = ls && (run || streak >= S);
        lostp = loss;
        if (loss) total++;
        det.push_back(ms[n] && !ms[n-1]);
        ms.push_back(cm);
        m_fv = (n % WIN) == 0;
        if (m_fv) begin
            s = 0;
            for (int i = n - WIN + 1; i <= n; i++) s += int'(det[i]);
            m_freq = s > 65535 ? 65535 : s;
        end
    endfunction

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk_tb);
        if (rst_n) m_step(mif.pll_lock, mif.clk_mon);
        else m_reset();
        #1;
        chk("sys_rst_n", int'(mif.sys_rst_n), int'(run));
        chk("locked_ok", int'(mif.locked_ok), int'(run));
        chk("loss_cnt", int'(mif.loss_cnt), total > LMAX ? LMAX : total);
        chk("err_flag", int'(mif.err_flag), int'(total >= 2));
        chk("freq_cnt", int'(mif.freq_cnt), m_freq);
        chk("freq_valid", int'(mif.freq_valid), int'(m_fv));
        if (m_fv && fixed_mon) chk("freq_25_26", int'(mif.freq_cnt >= 25 && mif.freq_cnt <= 26), 1);
    endtask

    typedef struct {bit lock; int cyc; bit run; int loss; bit err;} vec_t;
    vec_t tbl[$];

    initial begin
        checks = 0; fails = 0;
        rst_n = 0; mif.pll_lock = 0; mon_half = 10; fixed_mon = 1;
        m_reset();
        repeat (3) tick();
        chk("rst_sys_rst_n", int'(mif.sys_rst_n), 0);
        chk("rst_loss_cnt", int'(mif.loss_cnt), 0);
        chk("rst_freq_valid", int'(mif.freq_valid), 0);
        rst_n = 1;
        m_reset();
        tbl.push_back('{1, 17, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0});
        tbl.push_back('{1, 10, 1, 0, 0});
        tbl.push_back('{0, 5, 0, 1, 0});
        tbl.push_back('{1, 17, 0, 1, 0});
        tbl.push_back('{1, 1, 1, 1, 0});
        for (int k = 2; k <= 8; k++) begin
            tbl.push_back('{0, 3, 0, k > LMAX ? LMAX : k, 1});
            tbl.push_back('{1, 18, 1, k > LMAX ? LMAX : k, 1});
        end
        foreach (tbl[i]) begin
            mif.pll_lock = tbl[i].lock;
            repeat (tbl[i].cyc) tick();
            chk($sformatf("vec%0d_sys_rst_n", i), int'(mif.sys_rst_n), int'(tbl[i].run));
            chk($sformatf("vec%0d_locked_ok", i), int'(mif.locked_ok), int'(tbl[i].run));
            chk($sformatf("vec%0d_loss_cnt", i), int'(mif.loss_cnt), tbl[i].loss);
            chk($sformatf("vec%0d_err_flag", i), int'(mif.err_flag), int'(tbl[i].err));
        end
        #0.3 rst_n = 0;
        #0.2;
        chk("async_sys_rst_n", int'(mif.sys_rst_n), 0);
        chk("async_locked_ok", int'(mif.locked_ok), 0);
        repeat (3) tick();
        chk("async_loss_cnt", int'(mif.loss_cnt), 0);
        chk("async_err_flag", int'(mif.err_flag), 0);
        chk("async_freq_cnt", int'(mif.freq_cnt), 0);
        rst_n = 1;
        m_reset();
        repeat (10) tick();
        mif.pll_lock = 0;
        repeat (5) tick();
        chk("glitch_sys_rst_n", int'(mif.sys_rst_n), 0);
        chk("glitch_loss_cnt", int'(mif.loss_cnt), 0);
        mif.pll_lock = 1;
        repeat (17) tick();
        chk("reacq_early", int'(mif.sys_rst_n), 0);
        tick();
        chk("reacq_sys_rst_n", int'(mif.sys_rst_n), 1);
        chk("reacq_locked_ok", int'(mif.locked_ok), 1);
        fixed_mon = 0;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 4) == 0) mon_half = $urandom_range(3, 9);
            if (k == 75) begin
                rst_n = 0;
                repeat (2) tick();
                rst_n = 1;
                m_reset();
            end
            mif.pll_lock = $urandom_range(0, 1);
            repeat ($urandom_range(1, 40)) tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
